// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bundle: I/D cache miss-engine handshakes plus the main-memory beat port.
// The master modport is the arbiter's view; slave is the caches-plus-memory view.
interface mem_port_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        i_done;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_wnext;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_done;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
      output i_gnt, i_rvalid, i_rdata, i_done,
      output d_wnext, d_gnt, d_rvalid, d_rdata, d_done,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
      input  i_gnt, i_rvalid, i_rdata, i_done,
      input  d_wnext, d_gnt, d_rvalid, d_rdata, d_done,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin I/D line-burst arbiter: grant cycle + 2^LINE_ADDR_LEN beats + one DONE cycle.
// Backpressure: mem_ready low stalls the beat counter and holds address/control; no timeout.
module mem_port_arbiter #(
   parameter int LINE_ADDR_LEN = 3
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.master  bus
);
   localparam int BL = 1 << LINE_ADDR_LEN;
   localparam int CW = (LINE_ADDR_LEN > 0) ? LINE_ADDR_LEN : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BL - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [31:0]   LINE_MASK = ~((32'd1 << (LINE_ADDR_LEN + 2)) - 32'd1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_I = 2'd1;
   localparam logic [1:0] BUSY_D = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   logic [1:0]    state;
   logic          owner;
   logic          we_lat;
   logic          last_owner;
   logic [31:0]   base;
   logic [CW-1:0] cnt;

   logic busy_i, busy_d, busy, in_done, beat, last_beat, pick_d;

   assign busy_i    = (state == BUSY_I);
   assign busy_d    = (state == BUSY_D);
   assign busy      = busy_i | busy_d;
   assign in_done   = (state == DONE);
   assign beat      = busy & bus.mem_ready;
   assign last_beat = beat & (cnt == CNT_LAST);

   // D wins when alone, or on a tie when I was served last.
   assign pick_d = bus.d_req & (~bus.i_req | (last_owner == OWN_I));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         owner      <= OWN_I;
         we_lat     <= 1'b0;
         last_owner <= OWN_I;
         base       <= 32'd0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_req | bus.d_req) begin
                  state      <= pick_d ? BUSY_D : BUSY_I;
                  owner      <= pick_d ? OWN_D : OWN_I;
                  last_owner <= pick_d ? OWN_D : OWN_I;
                  we_lat     <= pick_d & bus.d_we;
                  base       <= (pick_d ? bus.d_addr : bus.i_addr) & LINE_MASK;
                  cnt        <= '0;
               end
            end
            BUSY_I, BUSY_D: begin
               if (last_beat) begin
                  cnt   <= '0;
                  state <= DONE;
               end else if (beat) begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_req   = busy;
   assign bus.mem_we    = busy & we_lat;
   assign bus.mem_addr  = busy ? (base + {{(30 - CW){1'b0}}, cnt, 2'b00}) : 32'd0;
   assign bus.mem_wdata = busy_d ? bus.d_wdata : 32'd0;

   assign bus.i_gnt    = busy_i | (in_done & (owner == OWN_I));
   assign bus.i_done   = in_done & (owner == OWN_I);
   assign bus.i_rvalid = beat & busy_i;
   assign bus.i_rdata  = (beat & busy_i) ? bus.mem_rdata : 32'd0;

   assign bus.d_gnt    = busy_d | (in_done & (owner == OWN_D));
   assign bus.d_done   = in_done & (owner == OWN_D);
   assign bus.d_rvalid = beat & busy_d & ~we_lat;
   assign bus.d_rdata  = (beat & busy_d & ~we_lat) ? bus.mem_rdata : 32'd0;
   assign bus.d_wnext  = beat & busy_d & we_lat;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, I read, D/I tie round robin, stalled D write, mid-burst reset.
module tb_mem_port_arbiter;
   localparam int LINE_ADDR_LEN = 3;
   localparam int BL = 1 << LINE_ADDR_LEN;
   localparam logic [31:0] RD_PAT = 32'hC0DE_0000;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.LINE_ADDR_LEN(LINE_ADDR_LEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Memory model: read data is a fixed function of the beat address.
   assign bus.mem_rdata = bus.mem_addr ^ RD_PAT;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
      check({tag, "_gnt"}, {30'd0, bus.i_gnt, bus.d_gnt}, 32'd0);
      check({tag, "_done"}, {30'd0, bus.i_done, bus.d_done}, 32'd0);
      check({tag, "_strobes"}, {29'd0, bus.i_rvalid, bus.d_rvalid, bus.d_wnext}, 32'd0);
      check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
      check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
      check({tag, "_rdata"}, bus.i_rdata | bus.d_rdata | bus.mem_wdata, 32'd0);
   endtask

   // Starts in the IDLE grant cycle with requests already raised; ends in the
   // following IDLE cycle (full burst) or right after the last requested beat.
   task automatic run_burst(input bit is_d, input bit we, input logic [31:0] base,
                            input bit toggle, input int nbeats);
      int   beats = 0;
      int   cyc = 0;
      bit   rdy = 1'b1;
      logic [31:0] exp_addr;
      @(negedge clk);
      check("grant_cycle_gnt", {30'd0, bus.i_gnt, bus.d_gnt}, 32'd0);
      check("grant_cycle_mem_req", 32'(bus.mem_req), 32'd0);
      next_cycle();
      while (beats < nbeats && cyc < 64) begin
         bus.mem_ready = rdy;
         bus.d_wdata   = 32'hD000_0000 | 32'(beats);
         exp_addr      = base + 32'(4 * beats);
         @(negedge clk);
         check("mem_req", 32'(bus.mem_req), 32'd1);
         check("owner_gnt", {30'd0, bus.i_gnt, bus.d_gnt}, is_d ? 32'd1 : 32'd2);
         check("mem_addr", bus.mem_addr, exp_addr);
         check("mem_we", 32'(bus.mem_we), 32'(we));
         if (is_d) begin
            check("d_rvalid", 32'(bus.d_rvalid), 32'(rdy & ~we));
            check("d_wnext", 32'(bus.d_wnext), 32'(rdy & we));
            check("i_rvalid_idle", 32'(bus.i_rvalid), 32'd0);
            check("mem_wdata", bus.mem_wdata, 32'hD000_0000 | 32'(beats));
            if (rdy && !we) check("d_rdata", bus.d_rdata, exp_addr ^ RD_PAT);
         end else begin
            check("i_rvalid", 32'(bus.i_rvalid), 32'(rdy));
            check("d_strobes_idle", {30'd0, bus.d_rvalid, bus.d_wnext}, 32'd0);
            check("mem_wdata_i", bus.mem_wdata, 32'd0);
            if (rdy) check("i_rdata", bus.i_rdata, exp_addr ^ RD_PAT);
         end
         if (rdy) beats++;
         next_cycle();
         cyc++;
         if (toggle) rdy = ~rdy;
      end
      if (beats < nbeats) check("burst_timeout", 32'(beats), 32'(nbeats));
      if (nbeats == BL) begin
         bus.mem_ready = 1'b1;
         @(negedge clk);
         check("done_pulse", {30'd0, bus.i_done, bus.d_done}, is_d ? 32'd1 : 32'd2);
         check("done_gnt", {30'd0, bus.i_gnt, bus.d_gnt}, is_d ? 32'd1 : 32'd2);
         check("done_mem_req", 32'(bus.mem_req), 32'd0);
         check("done_strobes", {29'd0, bus.i_rvalid, bus.d_rvalid, bus.d_wnext}, 32'd0);
         if (is_d) bus.d_req = 1'b0;
         else      bus.i_req = 1'b0;
         next_cycle();
      end
   endtask

   task automatic do_reset();
      rst           = 1'b0;
      bus.i_req     = 1'b0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.mem_ready = 1'b1;
      repeat (2) next_cycle();
      rst = 1'b1;
   endtask

   initial begin
      rst         = 1'b0;
      bus.i_req   = 1'b0;
      bus.i_addr  = 32'd0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'd0;
      bus.d_wdata = 32'd0;
      bus.mem_ready = 1'b1;

      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_quiet("reset_idle");
         next_cycle();
      end

      // Single I line read, mid-line address.
      bus.i_addr = 32'h0000_1234;
      bus.i_req  = 1'b1;
      run_burst(1'b0, 1'b0, 32'h0000_1220, 1'b0, BL);
      @(negedge clk);
      check_quiet("after_i_read");
      next_cycle();

      // Tie straight after reset: D first, then I while D re-requests, then D.
      do_reset();
      bus.i_addr = 32'h0000_3000;
      bus.d_addr = 32'h0000_2010;
      bus.d_we   = 1'b0;
      bus.i_req  = 1'b1;
      bus.d_req  = 1'b1;
      run_burst(1'b1, 1'b0, 32'h0000_2000, 1'b0, BL);
      bus.d_addr = 32'h0000_2044;
      bus.d_req  = 1'b1;
      run_burst(1'b0, 1'b0, 32'h0000_3000, 1'b0, BL);
      run_burst(1'b1, 1'b0, 32'h0000_2040, 1'b0, BL);

      // D writeback with mem_ready toggling.
      bus.d_we   = 1'b1;
      bus.d_addr = 32'h0000_0040;
      bus.d_req  = 1'b1;
      run_burst(1'b1, 1'b1, 32'h0000_0040, 1'b1, BL);
      bus.d_we   = 1'b0;
      @(negedge clk);
      check_quiet("after_d_write");
      next_cycle();

      // Reset in the middle of a D read: no done, next I burst uses its own base.
      bus.d_addr = 32'h0000_0100;
      bus.d_req  = 1'b1;
      run_burst(1'b1, 1'b0, 32'h0000_0100, 1'b0, 3);
      rst = 1'b0;
      next_cycle();
      rst       = 1'b1;
      bus.d_req = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_quiet("mid_reset");
         next_cycle();
      end
      bus.i_addr = 32'h0000_0A08;
      bus.i_req  = 1'b1;
      run_burst(1'b0, 1'b0, 32'h0000_0A00, 1'b0, BL);
      @(negedge clk);
      check_quiet("final_idle");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path (I side, read-only) and the data-cache refill/writeback path (D side, read or write).
- Every transaction is a full cache-line burst of 2^LINE_ADDR_LEN words.
- Sits between both cache miss engines and main memory. It arbitrates, sequences the burst beats, and signals completion so that stall logic can release the pipeline.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line; burst length BL = 2^LINE_ADDR_LEN (allowed range 0..5).

Ports:
- clk  in  1  clock, all state updates on its rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- i_req  in  1  I-side line read request, held high until i_done
- i_addr  in  32  I-side byte address, any word in the line
- i_gnt  out  1  I side owns the memory port
- i_rvalid  out  1  i_rdata holds a valid beat
- i_rdata  out  32  I-side read beat
- i_done  out  1  one-cycle pulse: I burst complete
- d_req  in  1  D-side request, held high until d_done
- d_we  in  1  1 = line write (writeback), 0 = line read; sampled at grant
- d_addr  in  32  D-side byte address
- d_wdata  in  32  write beat; must show beat k while d_wnext is pending for beat k
- d_wnext  out  1  current write beat accepted; requester advances to next word
- d_gnt  out  1  D side owns the memory port
- d_rvalid  out  1  d_rdata holds a valid beat
- d_rdata  out  32  D-side read beat
- d_done  out  1  one-cycle pulse: D burst complete
- mem_req  out  1  memory beat request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned beat address
- mem_wdata  out  32  write data
- mem_ready  in  1  memory accepts/returns the current beat this cycle
- mem_rdata  in  32  read data, valid when mem_ready=1

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- Registers: owner, we_lat, base (32), cnt (LINE_ADDR_LEN bits), last_owner.

Arbitration (IDLE):
- Only i_req: go to BUSY_I.
- Only d_req: go to BUSY_D.
- Both: grant the side that is not last_owner (round robin).
- Neither: stay in IDLE.
- At grant: latch base = addr with bits [LINE_ADDR_LEN+1:0] cleared, set cnt = 0, latch we_lat = d_we (forced to 0 for the I side), set last_owner to the winner.

BUSY_x:
- mem_req = 1, mem_addr = base + 4*cnt, mem_we = we_lat.
- mem_wdata = d_wdata when D owns the port, otherwise 0.
- Each cycle with mem_ready = 1:
  - cnt increments.
  - Read: x_rvalid = 1 and x_rdata = mem_rdata combinationally in the same cycle.
  - Write: d_wnext = 1 in the same cycle.
- mem_ready = 0: hold all outputs, no beat consumed, no timeout.
- Last beat (cnt = BL-1 with mem_ready = 1): go to DONE. cnt wraps to 0.

DONE:
- Lasts exactly one cycle.
- mem_req = 0 and x_done = 1 for the owner.
- Next state is always IDLE. Requests are ignored in DONE, so a new grant happens at the earliest 2 cycles after the last beat.

Grant and idle signalling:
- x_gnt = 1 in BUSY_x and in DONE for that owner.
- Outside BUSY, all *_rvalid, d_wnext and mem_we are 0, and the rdata/wdata outputs are 0.
- Requests arriving mid-burst wait. Neither side is ever granted twice in a row while the other side is requesting.
- Requester dropping x_req mid-burst: the burst still completes, with no abort.
- Throughput: with mem_ready tied to 1, a burst takes grant cycle + BL beats + DONE.

Reset (rst = 0 at a clock edge, including mid-burst):
- state = IDLE, cnt = 0, base = 0, we_lat = 0, last_owner = I (so D wins the first tie).
- All outputs are 0 the following cycle.
- A burst in flight is abandoned and no done pulse is issued.

Test Plan:
- Reset held 2 cycles, then released with no requests -> all outputs 0, mem_req stays 0.
- i_req with i_addr = 0x0000_1234 and mem_ready tied to 1:
  - mem_addr sequence 0x1220, 0x1224 … 0x123C over 8 consecutive cycles.
  - i_rvalid high for those 8 cycles, i_rdata = mem_rdata each cycle.
  - i_done pulses on the next cycle.
- i_req and d_req rise on the same cycle after reset:
  - D granted first; I granted 2 cycles after D's last beat.
  - Re-raising both afterwards: I served first (round robin).
- d_req with d_we = 1 and d_addr = 0x0000_0040, mem_ready toggling 1,0,1,0…:
  - d_wnext is high only on ready cycles.
  - mem_addr advances 0x40→0x5C only on ready cycles.
  - 8 writes total, mem_we = 1 throughout; d_done after the 8th accepted beat.
- Reset asserted after beat 3 of a D read -> next cycle mem_req = 0 and d_gnt = 0, no d_done; a fresh i_req afterwards starts at its own base address.
